// File: rtl/apb_arbiter_requester.sv
// rtl/apb_arbiter_requester.sv - round-robin arbiter sharing one APB completer among NUM_REQ clients
module apb_arbiter_requester #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          sel,
    output logic                          wr,
    output logic                          en,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          ready
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GW-1:0] LAST_REQ = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t               state;
    logic [GW-1:0]        rr;
    logic [GW-1:0]        grant;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [CW-1:0]        to_cnt;

    logic                  pick_valid;
    logic [GW-1:0]         pick;
    logic [NUM_REQ-1:0]    pick_oh;
    logic                  pick_wr;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [DATA_WIDTH-1:0] pick_wdata;
    logic                  timed_out;
    logic [GW-1:0]         next_rr;

    // First pending client at or above the rr pointer, wrapping at NUM_REQ.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        pick_oh    = '0;
        pick_wr    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pick_valid && req_valid[i] && (((int'(rr) + k) % NUM_REQ) == i)) begin
                    pick_valid = 1'b1;
                    pick       = GW'(i);
                    pick_oh[i] = 1'b1;
                    pick_wr    = req_wr[i];
                    pick_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    pick_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign timed_out = (TIMEOUT > 0) && (to_cnt == TO_LAST);
    assign next_rr   = (grant == LAST_REQ) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= '0;
            grant     <= '0;
            grant_oh  <= '0;
            to_cnt    <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            sel       <= 1'b0;
            wr        <= 1'b0;
            en        <= 1'b0;
            addr      <= '0;
            wr_data   <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    en <= 1'b0;
                    if (pick_valid) begin
                        grant     <= pick;
                        grant_oh  <= pick_oh;
                        req_ready <= pick_oh;
                        wr        <= pick_wr;
                        addr      <= pick_addr;
                        wr_data   <= pick_wdata;
                        sel       <= 1'b1;
                        to_cnt    <= '0;
                        state     <= SETUP;
                    end else begin
                        sel <= 1'b0;
                    end
                end
                SETUP: begin
                    en    <= 1'b1;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (ready) begin
                        rsp_valid <= grant_oh;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= wr ? '0 : rd_data;
                        sel       <= 1'b0;
                        en        <= 1'b0;
                        rr        <= next_rr;
                        state     <= IDLE;
                    end else if (timed_out) begin
                        rsp_valid <= grant_oh;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        sel       <= 1'b0;
                        en        <= 1'b0;
                        rr        <= next_rr;
                        state     <= IDLE;
                    end else begin
                        // Wraps harmlessly when the timeout is disabled.
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    sel   <= 1'b0;
                    en    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_arbiter_requester.sv
// tb/tb_apb_arbiter_requester.sv - scoreboard bench for apb_arbiter_requester with an SRAM completer model
module tb_apb_arbiter_requester;
    localparam int NR = 4;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_wr;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             sel;
    logic             wr;
    logic             en;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wr_data;
    logic [DW-1:0]    c_rdata;
    logic             c_ready;

    apb_arbiter_requester #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sel(sel), .wr(wr), .en(en), .addr(addr), .wr_data(wr_data),
        .rd_data(c_rdata), .ready(c_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            client;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } grant_t;

    typedef struct {
        int            client;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
    } rsp_t;

    grant_t gq[$];
    rsp_t   rq[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     acc_cyc = 0;

    int            cnt    [NR];
    logic          c_wr   [NR];
    logic [AW-1:0] c_addr [NR];
    logic [DW-1:0] c_wdata[NR];

    logic          stuck;
    int            wait_n;
    int            c_cnt;
    logic [DW-1:0] mem [0:1023];

    // SRAM completer with registered ready; wait_n extra wait states, stuck never answers.
    always @(posedge clk) begin
        if (rst) begin
            c_ready <= 1'b0;
            c_rdata <= '0;
            c_cnt   <= 0;
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (sel && en && !c_ready && !stuck) begin
            if (c_cnt == wait_n) begin
                c_ready <= 1'b1;
                c_cnt   <= 0;
                if (wr) mem[addr] <= wr_data;
                else    c_rdata   <= mem[addr];
            end else begin
                c_cnt <= c_cnt + 1;
            end
        end else begin
            c_ready <= 1'b0;
            if (!sel) c_cnt <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply_clients();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]           = (cnt[i] > 0);
            req_wr[i]              = c_wr[i];
            req_addr[i*AW +: AW]   = c_addr[i];
            req_wdata[i*DW +: DW]  = c_wdata[i];
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NR; i++) if (cnt[i] > 0) p = 1'b1;
        return p;
    endfunction

    task automatic xfer(input int client, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] rd, input logic err, input int lat, input bit want_rsp);
        grant_t g;
        rsp_t   r;
        g.client = client; g.w = w; g.a = a; g.d = d;
        gq.push_back(g);
        if (want_rsp) begin
            r.client = client; r.rdata = rd; r.err = err; r.lat = lat;
            rq.push_back(r);
        end
        c_wr[client]    = w;
        c_addr[client]  = a;
        c_wdata[client] = d;
        cnt[client]++;
    endtask

    task automatic drive();
        int n = 0;
        apply_clients();
        while (pending() && n < 200) begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) if (req_ready[i] && cnt[i] > 0) cnt[i]--;
            apply_clients();
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_wait: requests still pending after %0d cycles", n);
            for (int i = 0; i < NR; i++) cnt[i] = 0;
            apply_clients();
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((gq.size() != 0 || rq.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_wait: %0d grants / %0d responses outstanding", gq.size(), rq.size());
        end
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard on every accept/response and watches bus phases.
    initial begin : monitor
        grant_t        g;
        rsp_t          r;
        logic          prev_sel = 1'b0;
        logic          prev_en = 1'b0;
        logic [AW-1:0] h_addr = '0;
        logic [DW-1:0] h_wdata = '0;
        logic          h_wr = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_sel = 1'b0;
                prev_en  = 1'b0;
            end else begin
                if (req_ready != '0) begin
                    check("accept_rsp_overlap", 32'(rsp_valid), 0);
                    if (gq.size() == 0) begin
                        check("unexpected_grant", 32'(req_ready), 0);
                    end else begin
                        g = gq.pop_front();
                        check("grant_client", 32'(req_ready), 32'd1 << g.client);
                        check("setup_sel_en", {30'd0, sel, en}, 32'd2);
                        check("setup_addr", 32'(addr), 32'(g.a));
                        check("setup_wr", 32'(wr), 32'(g.w));
                        if (g.w) check("setup_wdata", 32'(wr_data), 32'(g.d));
                        acc_cyc = cyc;
                    end
                end
                if (rsp_valid != '0) begin
                    if (rq.size() == 0) begin
                        check("unexpected_rsp", 32'(rsp_valid), 0);
                    end else begin
                        r = rq.pop_front();
                        check("rsp_client", 32'(rsp_valid), 32'd1 << r.client);
                        check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                        check("rsp_err", 32'(rsp_err), 32'(r.err));
                        check("rsp_latency", cyc - acc_cyc, r.lat);
                        check("rsp_bus_idle", {30'd0, sel, en}, 0);
                    end
                end
                if (sel && !prev_sel) check("sel_without_accept", 32'(req_ready != '0), 1);
                if (sel && prev_sel) begin
                    check("access_en", 32'(en), 1);
                    check("addr_stable", 32'(addr), 32'(h_addr));
                    check("wr_stable", 32'(wr), 32'(h_wr));
                    check("wdata_stable", 32'(wr_data), 32'(h_wdata));
                end
                prev_sel = sel;
                prev_en  = en;
                h_addr   = addr;
                h_wr     = wr;
                h_wdata  = wr_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        stuck = 1'b0;
        wait_n = 0;
        for (int i = 0; i < NR; i++) begin
            cnt[i] = 0; c_wr[i] = 1'b0; c_addr[i] = '0; c_wdata[i] = '0;
        end
        apply_clients();
        repeat (2) @(posedge clk);
        #1;
        check("reset_sel_en_wr", {29'd0, sel, en, wr}, 0);
        check("reset_addr", 32'(addr), 0);
        check("reset_wdata", 32'(wr_data), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_rsp", {27'd0, rsp_valid, rsp_err}, 0);
        check("reset_rdata", 32'(rsp_rdata), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Simultaneous pairs: client0 then client1, twice.
        xfer(0, 1'b1, 10'd5, 16'hA5A5, 16'h0000, 1'b0, 3, 1'b1);
        xfer(1, 1'b1, 10'd6, 16'h5A5A, 16'h0000, 1'b0, 3, 1'b1);
        drive();
        wait_done();
        xfer(0, 1'b0, 10'd6, 16'h0000, 16'h5A5A, 1'b0, 3, 1'b1);
        xfer(1, 1'b0, 10'd5, 16'h0000, 16'hA5A5, 1'b0, 3, 1'b1);
        drive();
        wait_done();

        // Write then read back.
        xfer(0, 1'b1, 10'd3, 16'hBEEF, 16'h0000, 1'b0, 3, 1'b1);
        drive();
        wait_done();
        xfer(0, 1'b0, 10'd3, 16'h0000, 16'hBEEF, 1'b0, 3, 1'b1);
        drive();
        wait_done();

        // Timeout: completer never answers; rd_data still holds 0xBEEF.
        stuck = 1'b1;
        xfer(1, 1'b0, 10'd7, 16'h0000, 16'h0000, 1'b1, 17, 1'b1);
        drive();
        wait_done();
        check("after_timeout_idle", {30'd0, sel, en}, 0);

        // Reset in the middle of ACCESS; no response may follow.
        xfer(0, 1'b1, 10'd9, 16'h5555, 16'h0000, 1'b0, 0, 1'b0);
        drive();
        repeat (4) @(posedge clk);
        #1;
        check("mid_access_sel_en", {30'd0, sel, en}, 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_sel_en", {30'd0, sel, en}, 0);
        check("abort_rsp_valid", 32'(rsp_valid), 0);
        check("abort_req_ready", 32'(req_ready), 0);
        stuck = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // rr must be back at 0: client0 wins over client3.
        xfer(0, 1'b0, 10'd9, 16'h0000, 16'h0000, 1'b0, 3, 1'b1);
        xfer(3, 1'b1, 10'd9, 16'h7777, 16'h0000, 1'b0, 3, 1'b1);
        drive();
        wait_done();

        // Continuous contention: 0,1,2,3,0,1,2,3.
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < NR; i++)
                xfer(i, 1'b1, AW'(16 + i), DW'(16'h1000 + i), 16'h0000, 1'b0, 3, 1'b1);
        drive();
        wait_done();

        // Five completer wait states.
        wait_n = 5;
        xfer(2, 1'b0, 10'd18, 16'h0000, 16'h1002, 1'b0, 8, 1'b1);
        drive();
        wait_done();
        wait_n = 0;

        check("queues_drained", gq.size() + rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_arbiter_requester.md
Name: apb_arbiter_requester

Overview:
- Multi-requester APB requester that shares one APB completer (e.g. the SRAM completer) between NUM_REQ local clients.
- Arbitrates with round-robin priority and sequences the IDLE/SETUP/ACCESS phases.
- Waits on the completer's ready, returns read data or a timeout error to the granted client.
- Sits between client logic and the APB bus. Its APB outputs connect directly to the completer's sel/wr/en/addr/wr_data.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_WIDTH, 16, APB data width
- ADDR_WIDTH, 10, APB address width
- TIMEOUT, 16, max ACCESS cycles to wait for ready; 0 disables the timeout

Ports:
- clk  in  1  clock (PCLK)
- rst  in  1  synchronous active-high reset; one clock, all state cleared on the rising edge where rst=1
- req_valid  in  NUM_REQ  per-client request pending; held until accepted
- req_wr  in  NUM_REQ  per-client direction (1=write)
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened client addresses, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened client write data
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot
- rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot, to the granted client
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- sel  out  1  PSEL
- wr  out  1  PWRITE
- en  out  1  PENABLE
- addr  out  ADDR_WIDTH  PADDR
- wr_data  out  DATA_WIDTH  PWDATA
- rd_data  in  DATA_WIDTH  PRDATA
- ready  in  1  PREADY

Behaviour:
- All outputs registered. Reset values: every output 0. state=IDLE, rr pointer=0, grant=0, timeout count=0.
- Reset wins over everything. Reset mid-transfer drops sel/en next edge, issues no rsp_valid and no req_ready, and discards the transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning from the rr pointer upward with wrap.
  - Latch wr/addr/wr_data from that client and pulse req_ready[g].
  - Drive sel=1, en=0, and go to SETUP.
  - If no req_valid, hold sel=en=0.
- SETUP: always exactly one cycle. Set en=1 and go to ACCESS. addr/wr/wr_data are stable from SETUP until leaving ACCESS.
- ACCESS:
  - ready=1 sampled:
    - Pulse rsp_valid[g], rsp_err=0, rsp_rdata = rd_data for reads and 0 for writes.
    - Clear sel/en, set rr pointer = g+1 mod NUM_REQ, go to IDLE.
  - ready=0: increment the timeout count.
  - Timeout: when the count reaches TIMEOUT-1 with ready=0 (TIMEOUT>0), pulse rsp_valid[g] with rsp_err=1 and rsp_rdata=0. Clear sel/en, advance rr, go to IDLE.
  - The timeout count clears on entry to SETUP.
- Latency with a zero-wait-state completer: accept edge E0, SETUP at E0, ACCESS at E1, ready seen at E2, rsp_valid at E2. The completer's registered ready adds one ACCESS wait cycle, giving rsp_valid at E3.
- Bus gap: at least one IDLE cycle (sel=0) between transfers. This guarantees a stale ready from the previous transfer is never sampled.
- Ready is ignored in IDLE and SETUP.
- req_valid changing after acceptance has no effect. A client is never granted twice without its req_valid being resampled in IDLE.
- Fairness: with all clients continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0.
- req_ready and rsp_valid are never asserted in the same cycle.

Test Plan:
- Write then read: client0 writes addr 3, data 0xBEEF, then reads addr 3, against the SRAM completer. Required: req_ready[0] pulses; sel/en follow SETUP→ACCESS; rsp_valid[0] 3 edges after accept; read rsp_rdata=0xBEEF, rsp_err=0.
- Simultaneous requests: req_valid=2'b11 after reset. Required: client0 served first, then client1. A second simultaneous pair is served client0 then client1 again, since rr=0 after granting 1.
- Continuous contention, NUM_REQ=4: all four clients hold req_valid for 8 transfers. Required: grant order 0,1,2,3,0,1,2,3 with one idle cycle between each.
- Timeout: ready tied 0, TIMEOUT=16, client1 read. Required: rsp_valid[1] with rsp_err=1 and rsp_rdata=0 after 16 ACCESS cycles; sel=en=0 the next cycle.
- Reset mid-ACCESS: assert rst for 1 cycle during a client0 write. Required: sel/en/rsp_valid all 0 after the reset edge, no response pulse, and the next request goes to client0 (rr=0).
- Wait states: completer delays ready by 5 cycles. Required: en stays 1 and addr/wr_data stay stable throughout; rsp_valid fires on the edge ready is sampled.
